// File: rtl/ic_jpeg_pkg.sv
// Shared definitions for the JPEG byte packer/unpacker pair: pixel and word
// widths, byte-lane positions of the colour components, FSM state encoding
// and the helper that builds a padded flush word.
package ic_jpeg_pkg;

  localparam int PIX_W  = 24;
  localparam int WORD_W = 32;

  // Byte lanes of a pixel {B,G,R}
  localparam int LANE_R = 0;
  localparam int LANE_G = 1;
  localparam int LANE_B = 2;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Low 'res' bytes come from the residual register, the rest are 'pad'.
  function automatic logic [WORD_W-1:0] flush_word(input logic [PIX_W-1:0] resid,
                                                   input logic [1:0]       res,
                                                   input logic [7:0]       pad);
    logic [WORD_W-1:0] ext;
    logic [WORD_W-1:0] w;
    ext = {8'h00, resid};
    w   = '0;
    for (int k = 0; k < 4; k++) begin
      w[8*k +: 8] = (k < int'(res)) ? ext[8*k +: 8] : pad;
    end
    return w;
  endfunction

endpackage

// File: rtl/ic_ycbcrtorgb_24to32_if.sv
// Pixel input stream plus output-FIFO write port of the 24->32 packer.
interface ic_ycbcrtorgb_24to32_if;
  import ic_jpeg_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [PIX_W-1:0]  in_data;
  logic              in_last;
  logic              ff_full;
  logic              ff_wrreq;
  logic [WORD_W-1:0] ff_writedata;

  // Packer side
  modport slave (
    input  in_valid, in_data, in_last, ff_full,
    output in_ready, ff_wrreq, ff_writedata
  );

  // Pixel source / FIFO side
  modport master (
    output in_valid, in_data, in_last, ff_full,
    input  in_ready, ff_wrreq, ff_writedata
  );

endinterface

// File: rtl/ic_pack_outreg.sv
// One-deep output word register in front of the output FIFO. The word is
// written whenever the FIFO is not full; a load in the same cycle as a
// drain replaces the word so the register stays valid.
module ic_pack_outreg
  import ic_jpeg_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ff_full,
  input  logic              load,
  input  logic [WORD_W-1:0] load_word,
  input  logic              load_last,
  output logic              out_valid,
  output logic              ff_wrreq,
  output logic [WORD_W-1:0] ff_writedata,
  output logic              frame_done
);

  logic              out_valid_reg;
  logic [WORD_W-1:0] out_word_reg;
  logic              out_last_reg;
  logic              drain;

  assign drain        = out_valid_reg && !ff_full;
  assign out_valid    = out_valid_reg;
  assign ff_wrreq     = drain;
  assign ff_writedata = out_word_reg;
  assign frame_done   = drain && out_last_reg;

  // Load has priority over drain; an idle drain just empties the register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_reg <= 1'b0;
      out_word_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else if (load) begin
      out_valid_reg <= 1'b1;
      out_word_reg  <= load_word;
      out_last_reg  <= load_last;
    end else if (drain) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end
  end

endmodule

// File: rtl/ic_ycbcrtorgb_24to32.sv
// Packs 24-bit {B,G,R} pixels into 32-bit little-endian byte-packed words
// (4 pixels -> 3 words). A frame-end pixel that leaves bytes behind triggers
// a one-cycle flush that pads the partial word and marks it as frame end.
module ic_ycbcrtorgb_24to32
  import ic_jpeg_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic                    clk,
  input  logic                    reset_n,
  ic_ycbcrtorgb_24to32_if.slave   bus,
  output logic                    frame_done,
  output logic                    busy
);

  state_t            state_reg, state_next;
  logic [1:0]        res_reg, res_next;
  logic [PIX_W-1:0]  resid_reg, resid_next;

  logic              out_valid;
  logic              out_free;
  logic              accept;
  logic              load;
  logic [WORD_W-1:0] load_word;
  logic              load_last;
  logic              wrreq;
  logic [WORD_W-1:0] writedata;
  logic [7:0]        r, g, b;

  assign r = bus.in_data[8*LANE_R +: 8];
  assign g = bus.in_data[8*LANE_G +: 8];
  assign b = bus.in_data[8*LANE_B +: 8];

  // Output register can take a word if it is empty or being written now.
  assign out_free     = !out_valid || !bus.ff_full;
  assign bus.in_ready = (state_reg == ST_RUN) && out_free;
  assign accept       = bus.in_valid && bus.in_ready;
  assign busy         = (res_reg != 2'd0) || out_valid || (state_reg == ST_FLUSH);

  // Next residual/state and the word handed to the output register.
  always_comb begin
    state_next = state_reg;
    res_next   = res_reg;
    resid_next = resid_reg;
    load       = 1'b0;
    load_word  = '0;
    load_last  = 1'b0;
    if (state_reg == ST_RUN) begin
      if (accept) begin
        unique case (res_reg)
          2'd0: begin
            resid_next = {b, g, r};
            res_next   = 2'd3;
          end
          2'd3: begin
            load       = 1'b1;
            load_word  = {r, resid_reg[23:0]};
            resid_next = {8'h00, b, g};
            res_next   = 2'd2;
          end
          2'd2: begin
            load       = 1'b1;
            load_word  = {g, r, resid_reg[15:0]};
            resid_next = {16'h0000, b};
            res_next   = 2'd1;
          end
          2'd1: begin
            load       = 1'b1;
            load_word  = {b, g, r, resid_reg[7:0]};
            resid_next = '0;
            res_next   = 2'd0;
          end
        endcase
        if (bus.in_last) begin
          if (res_next != 2'd0) begin
            state_next = ST_FLUSH;
          end else begin
            load_last = 1'b1;
          end
        end
      end
    end else begin
      if (out_free) begin
        load       = 1'b1;
        load_word  = flush_word(resid_reg, res_reg, PAD_BYTE);
        load_last  = 1'b1;
        resid_next = '0;
        res_next   = 2'd0;
        state_next = ST_RUN;
      end
    end
  end

  // Packer state: FSM, residual byte count and residual bytes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_RUN;
      res_reg   <= 2'd0;
      resid_reg <= '0;
    end else begin
      state_reg <= state_next;
      res_reg   <= res_next;
      resid_reg <= resid_next;
    end
  end

  ic_pack_outreg u_outreg (
    .clk          (clk),
    .reset_n      (reset_n),
    .ff_full      (bus.ff_full),
    .load         (load),
    .load_word    (load_word),
    .load_last    (load_last),
    .out_valid    (out_valid),
    .ff_wrreq     (wrreq),
    .ff_writedata (writedata),
    .frame_done   (frame_done)
  );

  assign bus.ff_wrreq     = wrreq;
  assign bus.ff_writedata = writedata;

endmodule

// File: tb/tb_ic_ycbcrtorgb_24to32.sv
// Bench for the 24->32 pixel packer: per-cycle vector table for the directed
// scenarios, hand sequences for pad value and mid-frame reset, then random
// traffic checked against a byte-queue model of the packing rules.
module tb_ic_ycbcrtorgb_24to32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        ff_full = 1'b0;
  logic        frame_done, busy, frame_done2, busy2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ic_ycbcrtorgb_24to32_if bus();
  ic_ycbcrtorgb_24to32_if bus2();

  assign bus.in_valid  = in_valid;
  assign bus.in_data   = in_data;
  assign bus.in_last   = in_last;
  assign bus.ff_full   = ff_full;
  assign bus2.in_valid = in_valid;
  assign bus2.in_data  = in_data;
  assign bus2.in_last  = in_last;
  assign bus2.ff_full  = ff_full;

  ic_ycbcrtorgb_24to32 #(.PAD_BYTE(8'h00)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .frame_done(frame_done), .busy(busy));

  ic_ycbcrtorgb_24to32 #(.PAD_BYTE(8'hFF)) dut_ff (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .frame_done(frame_done2), .busy(busy2));

  typedef struct {
    logic        v;
    logic [23:0] d;
    logic        l;
    logic        f;
    logic        e_rdy;
    logic        e_wr;
    logic [31:0] e_word;
    logic        chk_word;
    logic        e_done;
    logic        e_busy;
  } vec_t;

  typedef struct {
    logic [31:0] w;
    logic        last;
  } exp_t;

  vec_t        vecs[$];
  exp_t        exp_q[$];
  logic [7:0]  byte_q[$];
  logic        use_model = 1'b0;
  logic [23:0] px[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a plain byte stream cut into 4-byte words.
  task automatic model_push(input logic [23:0] d, input logic l);
    exp_t e;
    byte_q.push_back(d[7:0]);
    byte_q.push_back(d[15:8]);
    byte_q.push_back(d[23:16]);
    while (byte_q.size() >= 4) begin
      e.w = '0;
      for (int k = 0; k < 4; k++) e.w[8*k +: 8] = byte_q.pop_front();
      e.last = l && (byte_q.size() == 0);
      exp_q.push_back(e);
    end
    if (l && byte_q.size() > 0) begin
      e.w = '0;
      for (int k = 0; byte_q.size() > 0; k++) e.w[8*k +: 8] = byte_q.pop_front();
      e.last = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  // One clock cycle: drive after the falling edge, sample 1 unit later.
  task automatic step(input logic v, input logic [23:0] d, input logic l,
                      input logic f, output logic acc);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_data = d; in_last = l; ff_full = f;
    #1;
    acc = v && bus.in_ready;
    if (use_model) begin
      if (bus.ff_wrreq) begin
        $display("write %h frame_done=%0b", bus.ff_writedata, frame_done);
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_write", 32'(bus.ff_wrreq), 32'(1'b0));
        end else begin
          e = exp_q.pop_front();
          chk("sb_word", bus.ff_writedata, e.w);
          chk("sb_done", 32'(frame_done), 32'(e.last));
        end
      end else begin
        chk("sb_idle_done", 32'(frame_done), 32'(1'b0));
      end
      if (acc) model_push(d, l);
    end
  endtask

  task automatic add(input logic v, input logic [23:0] d, input logic l, input logic f,
                     input logic rdy, input logic wr, input logic [31:0] w,
                     input logic cw, input logic dn, input logic bz);
    vec_t x;
    x.v = v; x.d = d; x.l = l; x.f = f; x.e_rdy = rdy; x.e_wr = wr;
    x.e_word = w; x.chk_word = cw; x.e_done = dn; x.e_busy = bz;
    vecs.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic [31:0] w0, w1, w2;
    px[0] = 24'h030201; px[1] = 24'h060504; px[2] = 24'h090807; px[3] = 24'h0C0B0A;
    w0 = 32'h04030201; w1 = 32'h08070605; w2 = 32'h0C0B0A09;

    // Streaming; last on P3 needs no flush
    add(1, px[0], 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, px[1], 0, 0, 1, 0, 0, 0, 0, 1);
    add(1, px[2], 0, 0, 1, 1, w0, 0, 0, 1);
    add(1, px[3], 1, 0, 1, 1, w1, 0, 0, 1);
    add(0, 0,     0, 0, 1, 1, w2, 0, 1, 1);
    add(0, 0,     0, 0, 1, 0, 0, 0, 0, 0);
    // Flush at res 3 (in_last without in_valid must be ignored)
    add(1, px[0], 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0,     0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0,     1, 0, 1, 1, 32'h00030201, 0, 1, 1);
    add(0, 0,     0, 0, 1, 0, 0, 0, 0, 0);
    // Flush at res 2
    add(1, px[0], 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, px[1], 1, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0,     0, 0, 0, 1, w0, 0, 0, 1);
    add(0, 0,     0, 0, 1, 1, 32'h00000605, 0, 1, 1);
    add(0, 0,     0, 0, 1, 0, 0, 0, 0, 0);
    // Flush at res 1
    add(1, px[0], 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, px[1], 0, 0, 1, 0, 0, 0, 0, 1);
    add(1, px[2], 1, 0, 1, 1, w0, 0, 0, 1);
    add(0, 0,     0, 0, 0, 1, w1, 0, 0, 1);
    add(0, 0,     0, 0, 1, 1, 32'h00000009, 0, 1, 1);
    add(0, 0,     0, 0, 1, 0, 0, 0, 0, 0);
    // Backpressure on word0 for 5 cycles, then drain + accept together
    add(1, px[0], 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, px[1], 0, 0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) add(1, px[2], 0, 1, 0, 0, w0, 1, 0, 1);
    add(1, px[2], 0, 0, 1, 1, w0, 0, 0, 1);
    add(1, px[3], 1, 0, 1, 1, w1, 0, 0, 1);
    add(0, 0,     0, 0, 1, 1, w2, 0, 1, 1);
    add(0, 0,     0, 0, 1, 0, 0, 0, 0, 0);

    // Reset state
    #12;
    chk("rst_ready", 32'(bus.in_ready), 32'(1'b1));
    chk("rst_wrreq", 32'(bus.ff_wrreq), 32'(1'b0));
    chk("rst_wdata", bus.ff_writedata, 32'h0);
    chk("rst_done",  32'(frame_done), 32'(1'b0));
    chk("rst_busy",  32'(busy), 32'(1'b0));
    @(negedge clk);
    reset_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].f, acc);
      chk($sformatf("tbl%0d_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("tbl%0d_wrreq", i), 32'(bus.ff_wrreq), 32'(vecs[i].e_wr));
      if (vecs[i].e_wr || vecs[i].chk_word)
        chk($sformatf("tbl%0d_word", i), bus.ff_writedata, vecs[i].e_word);
      chk($sformatf("tbl%0d_done", i), 32'(frame_done), 32'(vecs[i].e_done));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      $display("vec %0d in=%h wr=%0b data=%h done=%0b", i, vecs[i].d, bus.ff_wrreq,
               bus.ff_writedata, frame_done);
    end

    // Pad byte 0xFF on the second instance: single-pixel frame
    step(1, px[0], 1, 0, acc);
    step(0, 0, 0, 0, acc);
    step(0, 0, 0, 0, acc);
    chk("padff_wrreq", 32'(bus2.ff_wrreq), 32'(1'b1));
    chk("padff_word",  bus2.ff_writedata, 32'hFF030201);
    chk("padff_done",  32'(frame_done2), 32'(1'b1));
    step(0, 0, 0, 0, acc);

    // Reset mid-frame with word0 pending
    step(1, px[0], 0, 0, acc);
    step(1, px[1], 0, 0, acc);
    step(0, 0, 0, 0, acc);
    chk("mid_pending", 32'(bus.ff_wrreq), 32'(1'b1));
    reset_n = 1'b0;
    #1;
    chk("mid_rst_wrreq", 32'(bus.ff_wrreq), 32'(1'b0));
    chk("mid_rst_wdata", bus.ff_writedata, 32'h0);
    chk("mid_rst_done",  32'(frame_done), 32'(1'b0));
    chk("mid_rst_busy",  32'(busy), 32'(1'b0));
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 0, 0, 0, acc);
    chk("mid_rel_ready", 32'(bus.in_ready), 32'(1'b1));
    chk("mid_rel_wrreq", 32'(bus.ff_wrreq), 32'(1'b0));

    // Resend P0..P3 under the model
    use_model = 1'b1;
    for (int i = 0; i < 4; i++) step(1, px[i], (i == 3), 0, acc);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, acc);
    chk("resend_drained", 32'(exp_q.size()), 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(3) != 0), 24'($urandom), ($urandom_range(7) == 0),
           ($urandom_range(3) == 0), acc);
    end
    // Close the open frame
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) step(1, 24'($urandom), 1, 0, acc);
    chk("final_last_accepted", 32'(acc), 32'(1'b1));
    for (int i = 0; i < 20 && (exp_q.size() != 0 || busy); i++) step(0, 0, 0, 0, acc);
    chk("final_exp_empty",  32'(exp_q.size()), 32'd0);
    chk("final_bytes_empty", 32'(byte_q.size()), 32'd0);
    chk("final_not_busy",   32'(busy), 32'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ic_ycbcrtorgb_24to32.md
# ic_ycbcrtorgb_24to32

Packs a stream of 24-bit RGB pixels (`{B,G,R}`) into 32-bit words for the decompression-side output FIFO: 4 pixels become 3 words, byte-packed with no gaps. It sits between the YCbCr→RGB converter and the Avalon write-master FIFO. It is the write-side counterpart of the compression path's 32→24 unpacker, and produces the identical memory byte order. A frame-end flush zero-pads a partial final word and signals completion.

## Interface
- `PAD_BYTE`, default `8'h00`: fill value for the unused bytes of a flushed partial word.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_data` and `in_last` are valid this cycle.
- `in_ready`  out  1  block accepts the pixel this cycle.
- `in_data`  in  24  pixel `{B[23:16], G[15:8], R[7:0]}`.
- `in_last`  in  1  qualifies the final pixel of a frame.
- `ff_full`  in  1  output FIFO full.
- `ff_wrreq`  out  1  write strobe to the output FIFO.
- `ff_writedata`  out  32  packed word.
- `frame_done`  out  1  one-cycle pulse when the last word of a frame is written.
- `busy`  out  1  residual bytes held, output word pending, or a flush is in progress.

## Operation
- **Byte stream order:** R0,G0,B0,R1,G1,B1,… The first byte of each word goes to bits [7:0] and byte k goes to [8k+7:8k].
  - word0 = `{R1,B0,G0,R0}`
  - word1 = `{G2,R2,B1,G1}`
  - word2 = `{B3,G3,R3,B2}`
- **Residual count `res`** (0..3) tracks bytes held in a 24-bit residual register. The transition taken is set by `res` at the moment of acceptance:
  - res 0: store 3 bytes, no word, next res = 3.
  - res 3: emit word, keep G,B, next res = 2.
  - res 2: emit word, keep B, next res = 1.
  - res 1: emit word, next res = 0.
- **Acceptance:** a pixel is accepted when `in_valid && in_ready`.
- **Output register:** one-deep, holding `out_valid`, `out_word` and `out_last`.
  - `ff_wrreq = out_valid && !ff_full` (combinational).
  - `ff_writedata = out_word`.
- **Ready:** `in_ready = (state==RUN) && (!out_valid || !ff_full)`.
- **States:**
  - RUN: normal packing as above.
  - FLUSH: entered when the accepted pixel has `in_last=1` and the next res ≠ 0. `in_ready=0`. When the output register is free or draining this cycle, load the residual bytes zero-extended with `PAD_BYTE` in the upper bytes, set `out_last=1`, set res to 0 and return to RUN.
- **Last pixel with next res = 0:** if `in_last` is accepted and next res = 0, the emitted word itself carries `out_last=1`.
- **frame_done:** asserted in the cycle `ff_wrreq && out_last`. It is combinational from the output register, gated by `ff_full`.
- **Reset values:** state RUN, res 0, residual 0, `out_valid` 0, `out_word` 0, `out_last` 0.
  - All outputs are therefore 0, except `in_ready`, which is 1 after reset.
- **Reset mid-frame:** residual bytes and any pending word are discarded, with no flush and no `frame_done`.
- **`in_last` with `in_valid=0`:** ignored.

## Timing
- **Latency:** a word-completing pixel accepted at edge N gives `ff_wrreq` high in cycle N+1 if `ff_full=0`.
- **Throughput:** one pixel per cycle with `ff_full` low. Output runs at 3 words per 4 pixels, with no bubbles in RUN.
- **Backpressure:** while `ff_full=1` with `out_valid=1`, the following hold:
  - `in_ready=0`;
  - the word is held stable;
  - no write occurs.
- **Drain:** when `ff_full` drops, the write and a new acceptance may occur in the same cycle.
- **FLUSH cost:** one extra cycle after the last pixel, more if the output register is blocked.
- **Simultaneous drain and load:** when the output register drains and reloads in the same cycle, the load wins. `out_valid` stays 1.

## Structure
- The shared package `ic_jpeg_pkg` holds the byte-lane constants and the state encoding (`ST_RUN`, `ST_FLUSH`). It is reused by the 32→24 unpacker's bench.
- One natural sub-module: `ic_pack_outreg`, a one-deep output register with full-based stall. It owns `ff_wrreq`, `ff_writedata` and `frame_done`.
- The residual register, res counter and FSM stay in the top module.

## Test plan
- **Streaming:** pixels `24'h030201`, `24'h060504`, `24'h090807`, `24'h0C0B0A`, one per cycle with `ff_full=0` → words `32'h04030201`, `32'h08070605`, `32'h0C0B0A09` on consecutive cycles starting 1 cycle after P1 is accepted.
- **Flush at res 3:** a single pixel `24'h030201` with `in_last=1` → `in_ready` drops for the FLUSH cycle, then word `32'h00030201` is written with `frame_done=1`. Repeat with `PAD_BYTE=8'hFF` → `32'hFF030201`.
- **Flush at res 2 and res 1:**
  - Last at P1 → writes `32'h04030201`, then `32'h00000605`, with `frame_done` on the second.
  - Last at P2 → the final word is `32'h00000009`.
- **Last at res 1, no flush:** last at P3 → no FLUSH cycle, and `frame_done` coincides with the write of `32'h0C0B0A09`.
- **Backpressure:** hold `ff_full=1` for 5 cycles while word0 is pending → no write, `in_ready=0`, data stable. Release → word0 is written and P2 is accepted in the same cycle; the byte sequence is unchanged.
- **Reset mid-frame:** assert `reset_n=0` after P1 is accepted → all outputs go to 0 immediately, asynchronously, with `in_ready=1` after release. P0..P3 resent afterwards → words as in the streaming scenario.
